weapon_rom_arbiter: RTL and testbench
=====================================

Name: weapon_rom_arbiter

Overview:
- Shares the single weapon sprite ROM between N_REQ requesters: player weapons, projectile sprites and the HUD weapon icon.
- The ROM holds 3 weapon types, each 36x36 pixels at 4 bits per pixel, and has 1-cycle registered read latency.
- Grants one request per cycle using round-robin arbitration.
- Computes and range-checks the flat ROM address, then returns the pixel tagged with the requester ID two cycles after grant.
- Sits between the sprite/pixel pipelines and the ROM instance.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..4; ID width is 2.
- W_SIZE, 36, sprite edge length in pixels.
- W_AMOUNT, 3, number of weapon types stored.
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= W_SIZE*W_SIZE*W_AMOUNT (3888).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request; held high until granted.
- wep_type  in  4*N_REQ  weapon type; requester i uses bits [4i+3:4i].
- wep_hc  in  10*N_REQ  column within the sprite; requester i uses bits [10i+9:10i].
- wep_vc  in  10*N_REQ  row within the sprite; requester i uses bits [10i+9:10i].
- gnt  out  N_REQ  one-hot grant, combinational, valid in the request cycle.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_data  in  4  ROM pixel; valid one cycle after rom_addr is presented.
- rsp_valid  out  1  response strobe.
- rsp_id  out  2  index of the requester that owns the response.
- rsp_pixel  out  4  returned pixel.
- rsp_err  out  1  request was out of range; rsp_pixel is forced to 0.
- err_count  out  8  saturating count of out-of-range requests.

Behaviour:
- Reset (RST=1 at a clock edge):
  - rom_addr=0, rsp_valid=0, rsp_id=0, rsp_err=0, err_count=0.
  - Pipeline valid bits are cleared.
  - Round-robin pointer last=N_REQ-1, so requester 0 wins first.
  - gnt is forced to 0 while RST=1.
  - In-flight responses are discarded and never appear after reset.
- Arbitration (cycle t):
  - Search req starting at index (last+1) mod N_REQ and wrapping; the first set bit i gets gnt[i]=1.
  - At most one gnt bit is set; gnt=0 when req=0.
  - On a grant, last<=i at the edge ending cycle t.
  - A requester whose gnt is high in cycle t deasserts req or presents a new request at that edge.
  - A requester never sees gnt without its own req.
  - A continuously requesting requester is granted at least once every N_REQ cycles.
- Stage A (edge ending t):
  - Registers valid_a, id_a=i and err_a.
  - err = (hc>=W_SIZE) | (vc>=W_SIZE) | (type>=W_AMOUNT).
  - rom_addr <= err ? 0 : hc + vc*W_SIZE + type*W_SIZE*W_SIZE.
  - Compute in 13 bits, then truncate to ADDR_W. Maximum legal address is 3887.
  - With no grant, valid_a=0 and rom_addr holds its previous value.
- ROM stage: the ROM captures rom_addr during t+1; rom_data is valid in t+2.
- Stage B (edge ending t+1): valid_b<=valid_a, id_b<=id_a, err_b<=err_a.
- Outputs in cycle t+2:
  - rsp_valid=valid_b, rsp_id=id_b, rsp_err=valid_b&err_b.
  - rsp_pixel = (valid_b & !err_b) ? rom_data : 0.
  - When rsp_valid=0: rsp_pixel=0, and rsp_id holds its previous value.
- Throughput and latency: one response per cycle sustained; grant-to-response latency is exactly 2 cycles; responses return in grant order.
- err_count increments at the Stage A edge for each granted erroneous request and saturates at 255.
- Precedence: RST dominates requests in the same cycle.

Test Plan:
- Reset, then req=0001 with type=1, hc=5, vc=2 → gnt=0001 in cycle t; rom_addr=1373 at t+1; rsp_valid=1, rsp_id=0 at t+2; rsp_pixel equals ROM word 1373.
- req=1111 held 8 cycles after reset → grants in order 0,1,2,3,0,1,2,3; 8 responses with matching IDs, each 2 cycles after its grant; no idle cycles.
- Boundaries: type=2, hc=35, vc=35 → rom_addr=3887, no error. Then hc=36 → rsp_err=1, rsp_pixel=0, rom_addr=0, err_count=1. Then type=3 → err_count=2.
- 300 consecutive out-of-range requests → err_count stops at 255 and never wraps.
- Requests in flight (grants at t and t+1), RST=1 at t+1 → gnt=0 during reset; no rsp_valid in t+2 or t+3; the next grant goes to requester 0.
- Only req[2] held high while the pointer is at 2 → requester 2 is granted every cycle (the pointer wraps back to itself); rsp_id=2 continuously.

Source files
------------

// File: rtl/weapon_rom_arbiter.sv
// Round-robin arbiter sharing the weapon sprite ROM; response 2 cycles after grant, in grant order.
// No backpressure: requesters hold req until gnt, and one request is granted per cycle.
module weapon_rom_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W_SIZE   = 36,
  parameter int W_AMOUNT = 3,
  parameter int ADDR_W   = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      req,
  input  logic [4*N_REQ-1:0]    wep_type,
  input  logic [10*N_REQ-1:0]   wep_hc,
  input  logic [10*N_REQ-1:0]   wep_vc,
  output logic [N_REQ-1:0]      gnt,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [3:0]            rom_data,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_id,
  output logic [3:0]            rsp_pixel,
  output logic                  rsp_err,
  output logic [7:0]            err_count
);

  localparam logic [9:0] W_SIZE_C = 10'(W_SIZE);
  localparam logic [3:0] W_AMT_C  = 4'(W_AMOUNT);
  localparam logic [1:0] LAST_RST = 2'(N_REQ - 1);

  logic [1:0]       last;
  logic [N_REQ-1:0] gnt_w;
  logic [N_REQ-1:0] req_sh;
  logic             found;
  logic [1:0]       sel_idx;
  logic [3:0]       sel_type;
  logic [9:0]       sel_hc;
  logic [9:0]       sel_vc;
  logic             sel_err;
  logic [12:0]      addr13;
  logic             grant;
  int               cand;

  logic             valid_a, err_a, valid_b, err_b;
  logic [1:0]       id_a, id_b;

  // Search starts just after the last winner and wraps, so a lone requester can win back-to-back.
  always_comb begin
    found   = 1'b0;
    cand    = 0;
    req_sh  = '0;
    sel_idx = '0;
    gnt_w   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found   = 1'b1;
        sel_idx = 2'(cand);
        gnt_w   = {{(N_REQ-1){1'b0}}, 1'b1} << cand;
      end
    end
    gnt   = RST ? '0 : gnt_w;
    grant = found && !RST;
  end

  always_comb begin
    sel_type = 4'(wep_type >> (4 * sel_idx));
    sel_hc   = 10'(wep_hc >> (10 * sel_idx));
    sel_vc   = 10'(wep_vc >> (10 * sel_idx));
    sel_err  = (sel_hc >= W_SIZE_C) || (sel_vc >= W_SIZE_C) || (sel_type >= W_AMT_C);
    // Only in-range requests use the sum, so 13 bits cannot overflow for them.
    addr13   = 13'(sel_hc) + 13'(sel_vc) * 13'(W_SIZE) + 13'(sel_type) * 13'(W_SIZE * W_SIZE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last      <= LAST_RST;
      rom_addr  <= '0;
      valid_a   <= 1'b0;
      id_a      <= '0;
      err_a     <= 1'b0;
      valid_b   <= 1'b0;
      id_b      <= '0;
      err_b     <= 1'b0;
      err_count <= '0;
    end else begin
      valid_a <= grant;
      if (grant) begin
        last     <= sel_idx;
        id_a     <= sel_idx;
        err_a    <= sel_err;
        rom_addr <= sel_err ? '0 : ADDR_W'(addr13);
        if (sel_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      valid_b <= valid_a;
      err_b   <= valid_a & err_a;
      if (valid_a) id_b <= id_a;
    end
  end

  assign rsp_valid = valid_b;
  assign rsp_id    = id_b;
  assign rsp_err   = valid_b & err_b;
  assign rsp_pixel = (valid_b && !err_b) ? rom_data : 4'd0;

endmodule

// File: tb/tb_weapon_rom_arbiter.sv
// Bench for weapon_rom_arbiter: vector table plus hand sequences, responses checked from a queue.
module tb_weapon_rom_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req;
  logic [15:0] wep_type;
  logic [39:0] wep_hc, wep_vc;
  logic [3:0]  gnt;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_pixel;
  logic        rsp_err;
  logic [7:0]  err_count;

  always #5 CLK = ~CLK;

  weapon_rom_arbiter #(.N_REQ(4), .W_SIZE(36), .W_AMOUNT(3), .ADDR_W(12)) dut (
    .CLK(CLK), .RST(RST), .req(req), .wep_type(wep_type), .wep_hc(wep_hc), .wep_vc(wep_vc),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_pixel(rsp_pixel), .rsp_err(rsp_err), .err_count(err_count)
  );

  function automatic logic [3:0] rom_fn(input logic [11:0] a);
    return 4'(a ^ (a >> 4) ^ (a >> 8) ^ 12'h5);
  endfunction

  always @(posedge CLK) rom_data <= rom_fn(rom_addr);

  typedef struct packed {
    logic [1:0]  id;
    logic        err;
    logic [3:0]  pix;
    logic [31:0] due;
  } rsp_t;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  typ;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [3:0]  gnt;
    logic [11:0] addr;
    logic        err;
  } vec_t;

  rsp_t       sb[$];
  vec_t       tbl[10];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         exp_err = 0;
  bit         mon_en = 1'b0;
  logic [1:0] last_id = 2'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_all(input logic [3:0] t, input logic [9:0] hc, input logic [9:0] vc);
    wep_type = {4{t}};
    wep_hc   = {4{hc}};
    wep_vc   = {4{vc}};
  endtask

  function automatic logic [1:0] gnt2id(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push(input logic [3:0] g, input logic [11:0] addr, input logic err);
    rsp_t e;
    e.id  = gnt2id(g);
    e.err = err;
    e.pix = err ? 4'd0 : rom_fn(addr);
    e.due = 32'(cyc + 2);
    sb.push_back(e);
    if (err && exp_err < 255) exp_err++;
  endtask

  // Response monitor: every cycle is either the due response or an idle cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due < 32'(cyc)) begin
        chk("rsp_lost", 32'(cyc), sb[0].due);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == 32'(cyc)) begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_pixel", {28'd0, rsp_pixel}, {28'd0, e.pix});
        last_id = e.id;
      end else begin
        chk("idle_rsp", {24'd0, rsp_valid, rsp_err, rsp_id, rsp_pixel},
            {24'd0, 1'b0, 1'b0, last_id, 4'd0});
      end
      if (RST) last_id = 2'd0;
    end
  end

  initial begin
    tbl[0] = '{4'b0001, 4'd1, 10'd5,    10'd2,    4'b0001, 12'd1373, 1'b0};
    tbl[1] = '{4'b0011, 4'd2, 10'd35,   10'd35,   4'b0010, 12'd3887, 1'b0};
    tbl[2] = '{4'b0011, 4'd2, 10'd36,   10'd35,   4'b0001, 12'd0,    1'b1};
    tbl[3] = '{4'b1001, 4'd3, 10'd0,    10'd0,    4'b1000, 12'd0,    1'b1};
    tbl[4] = '{4'b0110, 4'd0, 10'd0,    10'd0,    4'b0010, 12'd0,    1'b0};
    tbl[5] = '{4'b0110, 4'd0, 10'd0,    10'd36,   4'b0100, 12'd0,    1'b1};
    tbl[6] = '{4'b0101, 4'd1, 10'd35,   10'd0,    4'b0001, 12'd1331, 1'b0};
    tbl[7] = '{4'b0000, 4'd0, 10'd0,    10'd0,    4'b0000, 12'd1331, 1'b0};
    tbl[8] = '{4'b1100, 4'd0, 10'd10,   10'd1,    4'b0100, 12'd46,   1'b0};
    tbl[9] = '{4'b1010, 4'd15, 10'd1023, 10'd1023, 4'b1000, 12'd0,   1'b1};

    RST = 1'b1;
    req = 4'b1111;
    drive_all(4'd0, 10'd0, 10'd0);
    repeat (2) tick();
    @(negedge CLK);
    chk("gnt_in_reset", {28'd0, gnt}, 32'd0);
    tick();
    @(negedge CLK);
    chk("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    chk("rst_rsp", {28'd0, rsp_valid, rsp_err, rsp_id}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    tick();
    RST = 1'b0;
    req = 4'b0000;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      req = tbl[i].req;
      drive_all(tbl[i].typ, tbl[i].hc, tbl[i].vc);
      @(negedge CLK);
      chk($sformatf("gnt_vec%0d", i), {28'd0, gnt}, {28'd0, tbl[i].gnt});
      if (tbl[i].gnt != 4'd0) push(tbl[i].gnt, tbl[i].addr, tbl[i].err);
      tick();
      req = 4'b0000;
      @(negedge CLK);
      chk($sformatf("rom_addr_vec%0d", i), {20'd0, rom_addr}, {20'd0, tbl[i].addr});
    end
    repeat (3) tick();
    @(negedge CLK);
    chk("err_count_table", {24'd0, err_count}, 32'(exp_err));

    // All four requesting: strict rotation with back-to-back responses.
    for (int k = 0; k < 8; k++) begin
      tick();
      req = 4'b1111;
      for (int j = 0; j < 4; j++) begin
        wep_type[4*j +: 4]  = 4'(j % 3);
        wep_hc[10*j +: 10]  = 10'(j * 4 + k);
        wep_vc[10*j +: 10]  = 10'(k);
      end
      @(negedge CLK);
      chk($sformatf("gnt_rr%0d", k), {28'd0, gnt}, 32'(1 << (k % 4)));
      push(4'(1 << (k % 4)), 12'(((k % 4) * 4 + k) + k * 36 + ((k % 4) % 3) * 1296), 1'b0);
    end
    tick();
    req = 4'b0000;

    // Lone requester 2 keeps winning as the pointer wraps onto itself.
    for (int k = 0; k < 6; k++) begin
      tick();
      req = 4'b0100;
      drive_all(4'd2, 10'(k), 10'(k + 1));
      @(negedge CLK);
      chk($sformatf("gnt_self%0d", k), {28'd0, gnt}, 32'b0100);
      push(4'b0100, 12'(k + (k + 1) * 36 + 2592), 1'b0);
    end
    tick();
    req = 4'b0000;
    drive_all(4'd0, 10'd36, 10'd0);
    repeat (3) tick();

    for (int k = 0; k < 300; k++) begin
      tick();
      req = 4'b0001;
      @(negedge CLK);
      chk("err_count_sat", {24'd0, err_count}, 32'(exp_err));
      push(4'b0001, 12'd0, 1'b1);
    end
    tick();
    req = 4'b0000;
    repeat (3) tick();
    @(negedge CLK);
    chk("err_count_255", {24'd0, err_count}, 32'd255);

    // Reset lands while a granted request is still in flight.
    tick();
    req = 4'b0001;
    drive_all(4'd1, 10'd5, 10'd2);
    @(negedge CLK);
    chk("gnt_pre_rst", {28'd0, gnt}, 32'b0001);
    tick();
    RST = 1'b1;
    req = 4'b1111;
    @(negedge CLK);
    chk("gnt_rst_inflight", {28'd0, gnt}, 32'd0);
    tick();
    RST = 1'b0;
    req = 4'b0000;
    exp_err = 0;
    tick();
    @(negedge CLK);
    chk("err_count_after_rst", {24'd0, err_count}, 32'd0);
    tick();
    req = 4'b1111;
    @(negedge CLK);
    chk("gnt_after_rst", {28'd0, gnt}, 32'b0001);
    push(4'b0001, 12'd1373, 1'b0);
    tick();
    req = 4'b0000;
    repeat (4) tick();
    @(negedge CLK);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
